stack_alu_seq: RTL and testbench

Parametrised, sequential successor to the processor's combinational ALU. It keeps the 4-bit opcode map for opcodes 0–9 and adds shifts, plus iterative multiply and divide. It also adds a valid/ready handshake on the input and output sides and overflow / divide-by-zero status. The block sits between the stack-operand fetch stage and the write-back stage, and it stalls the pipeline while a multi-cycle operation is in progress.

---
 rtl/stack_alu_pkg.sv | 25 ++
 rtl/stack_alu_muldiv_iter.sv | 85 ++++++++
 rtl/stack_alu_seq.sv | 151 +++++++++++++++
 tb/tb_stack_alu_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/stack_alu_pkg.sv
// Shared opcode map and FSM state encoding for the sequential stack ALU.
package stack_alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_PASSA = 4'd5;
    localparam logic [3:0] OP_PASSB = 4'd6;
    localparam logic [3:0] OP_EQ    = 4'd7;
    localparam logic [3:0] OP_ZEROA = 4'd8;
    localparam logic [3:0] OP_LTU   = 4'd9;
    localparam logic [3:0] OP_SHL   = 4'd10;
    localparam logic [3:0] OP_SHR   = 4'd11;
    localparam logic [3:0] OP_MUL   = 4'd12;
    localparam logic [3:0] OP_DIV   = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/stack_alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// The final iteration is presented combinationally while o_done is high.
module stack_alu_muldiv_iter
    import stack_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_op_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_hi_nonzero,
    output logic             o_div_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             r_busy;
    logic             r_is_div;
    logic             r_div_zero;
    logic [CW-1:0]    r_cnt;
    // r_hi: product high half or partial remainder; r_lo: multiplier or quotient.
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_next_hi;
    logic [WIDTH-1:0] w_next_lo;

    always_comb begin
        w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_shift   = {r_hi, r_lo[WIDTH-1]};
        w_diff    = w_shift - {1'b0, r_opnd};
        w_ge      = (w_shift >= {1'b0, r_opnd});
        w_next_hi = w_sum[WIDTH:1];
        w_next_lo = {w_sum[0], r_lo[WIDTH-1:1]};
        if (r_is_div) begin
            w_next_hi = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            w_next_lo = {r_lo[WIDTH-2:0], w_ge};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_is_div   <= 1'b0;
            r_div_zero <= 1'b0;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_opnd     <= '0;
        end else if (i_start) begin
            r_busy     <= 1'b1;
            r_is_div   <= i_op_div;
            r_div_zero <= i_op_div && (i_b == '0);
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= i_op_div ? i_a : i_b;
            r_opnd     <= i_op_div ? i_b : i_a;
        end else if (r_busy) begin
            r_hi <= w_next_hi;
            r_lo <= w_next_lo;
            if (r_cnt == LAST) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_done       = r_busy && (r_cnt == LAST);
    assign o_result     = r_div_zero ? '1 : w_next_lo;
    assign o_hi_nonzero = !r_is_div && (|w_next_hi);
    assign o_div_zero   = r_div_zero;

endmodule

// File: rtl/stack_alu_seq.sv
// Sequential stack ALU with valid/ready handshake on both sides.
// Define STACK_ALU_MULDIV_EN to build the iterative multiply/divide datapath.
module stack_alu_seq
    import stack_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Oper,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             Overflow,
    output logic             DivZero
);
    localparam int SW = $clog2(WIDTH);
`ifdef STACK_ALU_MULDIV_EN
    localparam logic UNSUP_OVF = 1'b0;
`else
    localparam logic UNSUP_OVF = 1'b1;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_out;
    logic             r_ovf;
    logic             r_dz;

    logic             w_accept;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [SW-1:0]    w_shamt;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;

    assign w_accept = in_valid && in_ready;
    assign w_sum    = A + B;
    assign w_diff   = A - B;
    assign w_shamt  = B[SW-1:0];

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (Oper)
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:   w_res = A & B;
            OP_OR:    w_res = A | B;
            OP_XOR:   w_res = A ^ B;
            OP_PASSA: w_res = A;
            OP_PASSB: w_res = B;
            OP_EQ:    w_res = {{(WIDTH-1){1'b0}}, (A == B)};
            OP_ZEROA: w_res = {{(WIDTH-1){1'b0}}, (A == '0)};
            OP_LTU:   w_res = {{(WIDTH-1){1'b0}}, (B < A)};
            OP_SHL:   w_res = A << w_shamt;
            OP_SHR:   w_res = A >> w_shamt;
            // Only reaches the output when the iterative datapath is absent.
            OP_MUL, OP_DIV: w_ovf = UNSUP_OVF;
            default: begin
                w_res = '0;
                w_ovf = 1'b0;
            end
        endcase
    end

`ifdef STACK_ALU_MULDIV_EN
    logic             w_is_multi;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_result;
    logic             w_md_hi_nz;
    logic             w_md_dz;

    assign w_is_multi = (Oper == OP_MUL) || (Oper == OP_DIV);

    stack_alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_accept && w_is_multi),
        .i_op_div     (Oper == OP_DIV),
        .i_a          (A),
        .i_b          (B),
        .o_done       (w_md_done),
        .o_result     (w_md_result),
        .o_hi_nonzero (w_md_hi_nz),
        .o_div_zero   (w_md_dz)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_ovf   <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
`ifdef STACK_ALU_MULDIV_EN
                        if (w_is_multi) begin
                            r_state <= ST_BUSY;
                            r_out   <= '0;
                            r_ovf   <= 1'b0;
                            r_dz    <= 1'b0;
                        end else
`endif
                        begin
                            r_state <= ST_DONE;
                            r_out   <= w_res;
                            r_ovf   <= w_ovf;
                            r_dz    <= 1'b0;
                        end
                    end
                end
                ST_BUSY: begin
`ifdef STACK_ALU_MULDIV_EN
                    if (w_md_done) begin
                        r_state <= ST_DONE;
                        r_out   <= w_md_result;
                        r_ovf   <= w_md_hi_nz;
                        r_dz    <= w_md_dz;
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
                ST_DONE: begin
                    if (out_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign ALU_Out   = r_out;
    assign Overflow  = r_ovf;
    assign DivZero   = r_dz;

endmodule

// File: tb/tb_stack_alu_seq.sv
// Table-driven bench for stack_alu_seq at WIDTH=16, with a result scoreboard
// and hand-written reset-abort sequence; follows STACK_ALU_MULDIV_EN if defined.
module tb_stack_alu_seq;
    localparam int W = 16;
`ifdef STACK_ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   Oper = 4'd0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] ALU_Out;
    logic         Overflow;
    logic         DivZero;

    stack_alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Oper      (Oper),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALU_Out   (ALU_Out),
        .Overflow  (Overflow),
        .DivZero   (DivZero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] out;
        logic         ovf;
        logic         dz;
        int           hold;
    } vec_t;

    vec_t         vecs[$];
    logic [W+1:0] exp_q[$];
    int           n_vec = 0;
    int           n_bad = 0;
    int           cur_idx = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL vec %0d %s: got %h expected %h", cur_idx, name, act, exp);
        end
    endtask

    // Expected values are written for the full-featured build; without the
    // iterative datapath, MUL/DIV collapse to the unsupported-op result.
    task automatic add_vec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] out, input logic ovf, input logic dz, input int hold);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.out = out; v.ovf = ovf; v.dz = dz; v.hold = hold;
        if (!MD && (op == 4'd12 || op == 4'd13)) begin
            v.out = '0; v.ovf = 1'b1; v.dz = 1'b0;
        end
        vecs.push_back(v);
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_idle", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input vec_t v);
        int           lat;
        int           exp_lat;
        bit           leak;
        logic [W+1:0] exp;
        exp_lat = (MD && (v.op == 4'd12 || v.op == 4'd13)) ? W + 1 : 1;
        wait_ready();
        Oper = v.op; A = v.a; B = v.b; in_valid = 1'b1;
        exp_q.push_back({v.dz, v.ovf, v.out});
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        leak = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            Oper = 4'($urandom_range(0, 15));
            A = W'($urandom);
            B = W'($urandom);
            if (!out_valid && in_ready) leak = 1'b1;
        end while (!out_valid && lat < 40);
        check("latency", 32'(lat), 32'(exp_lat));
        check("in_ready_busy", 32'(leak), 32'd0);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        check("result", 32'({DivZero, Overflow, ALU_Out}), 32'(exp));
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'({DivZero, Overflow, ALU_Out}), 32'(exp));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("valid_drop", 32'(out_valid), 32'd0);
    endtask

    initial begin
        vec_t v;
        add_vec(4'd0,  16'h7FFF, 16'h0001, 16'h8000, 1, 0, 3);
        add_vec(4'd1,  16'h0003, 16'h0005, 16'hFFFE, 0, 0, 0);
        add_vec(4'd9,  16'd5,    16'd3,    16'h0001, 0, 0, 0);
        add_vec(4'd8,  16'h0000, 16'h1234, 16'h0001, 0, 0, 0);
        add_vec(4'd8,  16'h0005, 16'h0000, 16'h0000, 0, 0, 0);
        add_vec(4'd0,  16'h8000, 16'h8000, 16'h0000, 1, 0, 0);
        add_vec(4'd0,  16'hFFFF, 16'h0001, 16'h0000, 0, 0, 0);
        add_vec(4'd1,  16'h8000, 16'h0001, 16'h7FFF, 1, 0, 0);
        add_vec(4'd1,  16'h7FFF, 16'hFFFF, 16'h8000, 1, 0, 0);
        add_vec(4'd2,  16'hF0F0, 16'hFF00, 16'hF000, 0, 0, 0);
        add_vec(4'd3,  16'hF0F0, 16'h0F0F, 16'hFFFF, 0, 0, 0);
        add_vec(4'd4,  16'hAAAA, 16'hFFFF, 16'h5555, 0, 0, 0);
        add_vec(4'd5,  16'h1234, 16'h5678, 16'h1234, 0, 0, 0);
        add_vec(4'd6,  16'h1234, 16'h5678, 16'h5678, 0, 0, 0);
        add_vec(4'd7,  16'h1234, 16'h1234, 16'h0001, 0, 0, 0);
        add_vec(4'd7,  16'h1234, 16'h1235, 16'h0000, 0, 0, 0);
        add_vec(4'd9,  16'd3,    16'd5,    16'h0000, 0, 0, 0);
        add_vec(4'd9,  16'd5,    16'd5,    16'h0000, 0, 0, 0);
        add_vec(4'd10, 16'h0001, 16'h0004, 16'h0010, 0, 0, 0);
        add_vec(4'd10, 16'h8001, 16'h0011, 16'h0002, 0, 0, 0);
        add_vec(4'd11, 16'h8000, 16'h000F, 16'h0001, 0, 0, 0);
        add_vec(4'd11, 16'hF000, 16'h0024, 16'h0F00, 0, 0, 0);
        add_vec(4'd14, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 0, 0);
        add_vec(4'd15, 16'h7FFF, 16'h0001, 16'h0000, 0, 0, 0);
        add_vec(4'd12, 16'h0100, 16'h0100, 16'h0000, 1, 0, 0);
        add_vec(4'd12, 16'd12,   16'd13,   16'h009C, 0, 0, 0);
        add_vec(4'd12, 16'hFFFF, 16'hFFFF, 16'h0001, 1, 0, 0);
        add_vec(4'd12, 16'd3,    16'd3,    16'h0009, 0, 0, 0);
        add_vec(4'd13, 16'd100,  16'd7,    16'h000E, 0, 0, 0);
        add_vec(4'd13, 16'd5,    16'd0,    16'hFFFF, 0, 1, 2);
        add_vec(4'd13, 16'hFFFF, 16'h0001, 16'hFFFF, 0, 0, 0);
        add_vec(4'd13, 16'd3,    16'd5,    16'h0000, 0, 0, 0);
        add_vec(4'd0,  16'h0001, 16'h0001, 16'h0002, 0, 0, 0);

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_alu_out",   32'(ALU_Out),   32'd0);
        check("rst_overflow",  32'(Overflow),  32'd0);
        check("rst_divzero",   32'(DivZero),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            cur_idx = i;
            run_op(vecs[i]);
        end

        // Reset during an in-flight MUL (8th BUSY cycle, or DONE when the
        // iterative datapath is absent) must discard it asynchronously.
        cur_idx = 100;
        wait_ready();
        Oper = 4'd12; A = 16'h0100; B = 16'h0100; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (MD ? 8 : 1) @(negedge clk);
        check("pre_rst_valid", 32'(out_valid), MD ? 32'd0 : 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready",  32'(in_ready),  32'd1);
        check("abort_alu_out",   32'(ALU_Out),   32'd0);
        check("abort_overflow",  32'(Overflow),  32'd0);
        check("abort_divzero",   32'(DivZero),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cur_idx = 101;
        v.op = 4'd0; v.a = 16'd2; v.b = 16'd2; v.out = 16'd4; v.ovf = 0; v.dz = 0; v.hold = 0;
        run_op(v);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
